crc16_decode: RTL
=================

CRC16_DECODE -- requirements
Module: crc16_decode

Interface
REQ-001 SHALL have ports: clock  in  1  system clock; reset_n  in  1  asynchronous, active-low reset.
REQ-002 SHALL have ports: rx_start  in  1  sync/PID-start strobe from bit-unstuffer; rx_bit  in  1  received unstuffed bit; rx_valid  in  1  rx_bit qualifier; rx_eop  in  1  end-of-packet strobe.
REQ-003 SHALL have ports: pkt_out  out  72  PID+data, first received bit at [0]; pkt_valid  out  1  one-cycle completion pulse; crc_ok  out  1  residual matched; crc_err  out  1  residual mismatch; len_err  out  1  bit count not 88 at EOP.
REQ-004 SHALL use parameters/constants: PID_LEN 8, DATA_LEN 64, CRC16_LEN 16, TOTAL_LEN 88, CRC16_RESIDUAL 16'h800D.

Function
REQ-005 SHALL implement FSM states IDLE, RX_PID, RX_DATA, RX_CRC, WAIT_EOP, DONE.
REQ-006 SHALL accept one bit per cycle only when rx_valid=1; rx_valid=0 cycles hold all state, counters, and CRC register (gaps of any length).
REQ-007 SHALL, on rx_start in any state, clear bit counter, preset CRC register to all ones, clear crc_ok/crc_err/len_err, and enter RX_PID; rx_valid in that same cycle is ignored.
REQ-008 SHALL shift every accepted bit into a 72-bit right-shift SIPO (new bit at MSB) during RX_PID and RX_DATA only; after 72 bits, first bit sits at pkt_out[0].
REQ-009 SHALL exclude PID bits from the CRC; RX_PID -> RX_DATA after the 8th accepted bit.
REQ-010 SHALL update the CRC register on each accepted bit in RX_DATA and RX_CRC: fb=rx_bit^x15; x0<=fb; x2<=x1^fb; x15<=x14^fb; all others xi<=x(i-1).
REQ-011 SHALL move RX_DATA -> RX_CRC after 72nd total bit, RX_CRC -> WAIT_EOP after 88th total bit.
REQ-012 SHALL, in WAIT_EOP with rx_eop=1, set crc_ok={x15..x0}==CRC16_RESIDUAL, crc_err=its inverse, len_err=0, and enter DONE.
REQ-013 SHALL, on rx_eop in RX_PID/RX_DATA/RX_CRC (short packet), set len_err=1, crc_ok=0, crc_err=0, enter DONE.
REQ-014 SHALL, on an accepted bit in WAIT_EOP (long packet), set len_err=1, crc_ok=0, crc_err=0, enter DONE immediately (not waiting for rx_eop).
REQ-015 SHALL treat rx_eop and an accepted rx_valid in the same cycle as: bit accepted first, then EOP evaluated on the updated count.
REQ-016 SHALL assert pkt_valid for exactly the one cycle spent in DONE (cycle after the terminating event is sampled), then return to IDLE.
REQ-017 SHALL hold pkt_out, crc_ok, crc_err, len_err stable from DONE until next rx_start or reset; exactly one of crc_ok/crc_err/len_err is 1 while pkt_valid=1.
REQ-018 SHALL ignore rx_bit/rx_valid/rx_eop in IDLE.

Reset
REQ-019 SHALL on reset_n=0 asynchronously force: state IDLE, bit counter 0, CRC register 16'hFFFF, pkt_out 0, pkt_valid 0, crc_ok 0, crc_err 0, len_err 0.
REQ-020 SHALL, on reset mid-packet, discard the partial packet with no pkt_valid pulse.

Structure
REQ-021 SHALL place PID_LEN, DATA_LEN, CRC16_LEN, TOTAL_LEN, CRC16_RESIDUAL, polynomial taps and the state enum in shared package usb_pkg, reused by the encoder.
REQ-022 SHALL instantiate one sub-module SIPO_Register_Right #(72) (clock, reset_n, shift, D, Q[71:0]).
REQ-023 SHALL use a 7-bit bit counter; FSM, CRC register, counter and flag registers in this module.

Verification
REQ-024 Loopback: CRC16_Encode output into crc16_decode, pkt_in=72'h0123_4567_89AB_CDEF_C3 -> pkt_out=same value, pkt_valid one cycle after rx_eop, crc_ok=1.
REQ-025 Same stream with data bit 20 inverted -> pkt_valid=1, crc_err=1, crc_ok=0, len_err=0.
REQ-026 rx_eop after 40 bits -> len_err=1, crc_ok=0, crc_err=0, single pkt_valid pulse.
REQ-027 89 accepted bits, no rx_eop -> len_err=1 with pkt_valid on the cycle after the 89th bit.
REQ-028 Valid packet with random rx_valid gaps (0-5 cycles) -> identical result to REQ-024; rx_start after 30 bits then full valid packet -> one pkt_valid, crc_ok=1.
REQ-029 reset_n pulsed low after 50 bits -> all outputs 0 immediately, no pkt_valid; next full packet decodes with crc_ok=1.

Source files
------------

// File: rtl/usb_pkg.sv
// +--------------------------------------------------------------------------+
// | usb_pkg : shared USB packet lengths, CRC16 constants and rx FSM states   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

package usb_pkg;

  localparam int PID_LEN   = 8;
  localparam int DATA_LEN  = 64;
  localparam int CRC16_LEN = 16;
  localparam int PKT_LEN   = PID_LEN + DATA_LEN;
  localparam int TOTAL_LEN = PKT_LEN + CRC16_LEN;

  localparam int CNT_W = 7;
  localparam logic [CNT_W-1:0] PID_END   = CNT_W'(PID_LEN);
  localparam logic [CNT_W-1:0] DATA_END  = CNT_W'(PKT_LEN);
  localparam logic [CNT_W-1:0] TOTAL_END = CNT_W'(TOTAL_LEN);

  // x16 + x15 + x2 + 1, x16 implicit
  localparam logic [15:0] CRC16_POLY     = 16'h8005;
  localparam logic [15:0] CRC16_PRESET   = 16'hFFFF;
  localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RX_PID   = 3'd1,
    RX_DATA  = 3'd2,
    RX_CRC   = 3'd3,
    WAIT_EOP = 3'd4,
    DONE     = 3'd5
  } usb_rx_state_t;

  typedef struct packed {
    logic crc_ok;
    logic crc_err;
    logic len_err;
  } usb_rx_status_t;

  localparam usb_rx_status_t STATUS_CLEAR   = usb_rx_status_t'(3'b000);
  localparam usb_rx_status_t STATUS_LEN_ERR = usb_rx_status_t'(3'b001);

  // One serial step of the CRC register, x15 is the feedback tap.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
    logic fb;
    fb = din ^ crc[15];
    return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
  endfunction

  function automatic usb_rx_status_t crc_verdict(input logic [15:0] crc);
    usb_rx_status_t s;
    s.crc_ok  = (crc == CRC16_RESIDUAL);
    s.crc_err = (crc != CRC16_RESIDUAL);
    s.len_err = 1'b0;
    return s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/crc16_decode_sipo.sv
// +--------------------------------------------------------------------------+
// | SIPO_Register_Right : serial-in parallel-out, new bit enters at the MSB  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module SIPO_Register_Right #(
  parameter int WIDTH = 72
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             shift,
  input  logic             D,
  output logic [WIDTH-1:0] Q
);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      Q <= '0;
    end else if (shift) begin
      Q <= {D, Q[WIDTH-1:1]};
    end
  end

endmodule

`default_nettype wire

// File: rtl/crc16_decode.sv
// +--------------------------------------------------------------------------+
// | crc16_decode : USB data-packet receiver, PID+data capture, CRC16 check   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module crc16_decode
  import usb_pkg::*;
(
  input  logic                clock,
  input  logic                reset_n,
  input  logic                rx_start,
  input  logic                rx_bit,
  input  logic                rx_valid,
  input  logic                rx_eop,
  output logic [PKT_LEN-1:0]  pkt_out,
  output logic                pkt_valid,
  output logic                crc_ok,
  output logic                crc_err,
  output logic                len_err
);

  usb_rx_state_t  state, state_nxt;
  logic [CNT_W-1:0] bit_cnt, bit_cnt_nxt, cnt_inc;
  logic [15:0]    crc, crc_nxt;
  usb_rx_status_t status, status_nxt;
  logic           sipo_shift;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      bit_cnt <= '0;
      crc     <= CRC16_PRESET;
      status  <= STATUS_CLEAR;
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_cnt_nxt;
      crc     <= crc_nxt;
      status  <= status_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    crc_nxt     = crc;
    status_nxt  = status;
    sipo_shift  = 1'b0;
    cnt_inc     = bit_cnt + CNT_W'(1);

    if (rx_start) begin
      state_nxt   = RX_PID;
      bit_cnt_nxt = '0;
      crc_nxt     = CRC16_PRESET;
      status_nxt  = STATUS_CLEAR;
    end else begin
      case (state)
        RX_PID, RX_DATA, RX_CRC: begin
          if (rx_valid) begin
            bit_cnt_nxt = cnt_inc;
            sipo_shift  = (state != RX_CRC);
            if (state != RX_PID) begin
              crc_nxt = crc16_step(crc, rx_bit);
            end
            if (state == RX_PID && cnt_inc == PID_END) begin
              state_nxt = RX_DATA;
            end else if (state == RX_DATA && cnt_inc == DATA_END) begin
              state_nxt = RX_CRC;
            end else if (state == RX_CRC && cnt_inc == TOTAL_END) begin
              state_nxt = WAIT_EOP;
            end
          end
          // EOP is judged on the count and CRC that include this cycle's bit
          if (rx_eop) begin
            state_nxt  = DONE;
            status_nxt = (bit_cnt_nxt == TOTAL_END) ? crc_verdict(crc_nxt) : STATUS_LEN_ERR;
          end
        end
        WAIT_EOP: begin
          if (rx_valid) begin
            state_nxt  = DONE;
            status_nxt = STATUS_LEN_ERR;
          end else if (rx_eop) begin
            state_nxt  = DONE;
            status_nxt = crc_verdict(crc);
          end
        end
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  SIPO_Register_Right #(
    .WIDTH (PKT_LEN)
  ) u_sipo (
    .clock   (clock),
    .reset_n (reset_n),
    .shift   (sipo_shift),
    .D       (rx_bit),
    .Q       (pkt_out)
  );

  assign pkt_valid = (state == DONE);
  assign crc_ok    = status.crc_ok;
  assign crc_err   = status.crc_err;
  assign len_err   = status.len_err;

endmodule

`default_nettype wire
